iter_divider: RTL and testbench

- Multi-cycle radix-2 restoring divider for the execute stage.
- Inverse of the single-cycle Wallace-tree/Booth multiplier path: it implements DIV/DIVU/REM/REMU and the 32-bit W variants with RISC-V semantics.
- Produces quotient and remainder together.
- Uses a valid/ready handshake on both sides so the pipeline can stall on it.

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_restore_step.sv | 29 ++
 rtl/iter_divider.sv | 179 +++++++++++++++++
 tb/tb_iter_divider.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-2 restoring divider.
package div_pkg;

    localparam int unsigned WIDTH  = 64;
    localparam int unsigned WWIDTH = 32;
    localparam int unsigned CNT_W  = 6;

    localparam logic [WIDTH-1:0]  MIN_NEG64 = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WWIDTH-1:0] MIN_NEG32 = {1'b1, {(WWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Sign-extend a word-op value to full width.
    function automatic logic [WIDTH-1:0] sext_word(input logic [WWIDTH-1:0] x);
        return {{(WIDTH-WWIDTH){x[WWIDTH-1]}}, x};
    endfunction

    // Zero-extend a word-op value to full width.
    function automatic logic [WIDTH-1:0] zext_word(input logic [WWIDTH-1:0] x);
        return {{(WIDTH-WWIDTH){1'b0}}, x};
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step (combinational).
// Ports:
//   rem_in    partial remainder before the step (always < dsr)
//   bit_in    next dividend bit shifted into the remainder
//   dsr       divisor magnitude
//   rem_out_c partial remainder after the step
//   q_bit_c   quotient bit produced by the step
module div_restore_step #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] dsr,
    output logic [W-1:0] rem_out_c,
    output logic         q_bit_c
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // One extra bit holds the shifted remainder; borrow out of it means "restore".
    always_comb begin
        shifted   = {rem_in, bit_in};
        diff      = shifted - {1'b0, dsr};
        q_bit_c   = ~diff[W];
        rem_out_c = q_bit_c ? diff[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider: DIV/DIVU/REM/REMU and W variants
// with RISC-V semantics, valid/ready on both sides, flushable.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 abort any in-flight op, return to IDLE
//   in_valid/in_ready     request handshake (in_ready only in IDLE)
//   is_signed, is_word    op selection (signed / 32-bit word variant)
//   dividend, divisor     operands, latched at accept
//   out_valid/out_ready   result handshake; result held until accepted
//   quotient, remainder   results (word ops sign-extended from bit 31)
module iter_divider
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic             is_word,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             word_q, word_d;

    logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag;
    logic             a_neg, b_neg, div_zero, sgn_ovf;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_raw, q_sgn, r_sgn;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

    // Operand extension, magnitudes and special-case detection at accept.
    always_comb begin
        if (is_word) begin
            a_ext = is_signed ? sext_word(dividend[WWIDTH-1:0]) : zext_word(dividend[WWIDTH-1:0]);
            b_ext = is_signed ? sext_word(divisor[WWIDTH-1:0])  : zext_word(divisor[WWIDTH-1:0]);
        end else begin
            a_ext = dividend;
            b_ext = divisor;
        end
        a_neg    = is_signed & a_ext[WIDTH-1];
        b_neg    = is_signed & b_ext[WIDTH-1];
        a_mag    = a_neg ? WIDTH'(-a_ext) : a_ext;
        b_mag    = b_neg ? WIDTH'(-b_ext) : b_ext;
        div_zero = (b_ext == '0);
        if (is_word) begin
            sgn_ovf = is_signed && (dividend[WWIDTH-1:0] == MIN_NEG32)
                                && (divisor[WWIDTH-1:0] == '1);
        end else begin
            sgn_ovf = is_signed && (dividend == MIN_NEG64) && (divisor == '1);
        end
    end

    // Dividend bits leave quo_q from the MSB while quotient bits enter at the LSB.
    div_restore_step #(.W(WIDTH)) u_step (
        .rem_in    (rem_q),
        .bit_in    (quo_q[WIDTH-1]),
        .dsr       (dsr_q),
        .rem_out_c (step_rem),
        .q_bit_c   (step_q)
    );

    // Final sign fix-up of the last step's results.
    always_comb begin
        q_raw = {quo_q[WIDTH-2:0], step_q};
        q_sgn = q_neg_q ? WIDTH'(-q_raw) : q_raw;
        r_sgn = r_neg_q ? WIDTH'(-step_rem) : step_rem;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        word_d      = word_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d = is_word;
                    if (div_zero) begin
                        quotient_d  = '1;
                        remainder_d = is_word ? sext_word(dividend[WWIDTH-1:0]) : dividend;
                        state_d     = DONE;
                    end else if (sgn_ovf) begin
                        quotient_d  = is_word ? sext_word(dividend[WWIDTH-1:0]) : dividend;
                        remainder_d = '0;
                        state_d     = DONE;
                    end else begin
                        // Word dividends are left-aligned so the first step sees bit 31.
                        quo_d   = is_word ? {a_mag[WWIDTH-1:0], {(WIDTH-WWIDTH){1'b0}}} : a_mag;
                        rem_d   = '0;
                        dsr_d   = b_mag;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                        cnt_d   = is_word ? CNT_W'(WWIDTH - 1) : CNT_W'(WIDTH - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = q_raw;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    quotient_d  = word_q ? sext_word(q_sgn[WWIDTH-1:0]) : q_sgn;
                    remainder_d = word_q ? sext_word(r_sgn[WWIDTH-1:0]) : r_sgn;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush wins over any handshake in the same cycle.
        if (flush) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            word_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            word_q      <= word_d;
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_iter_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        is_signed;
    logic        is_word;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int n_cmp = 0;
    int n_bad = 0;

    iter_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .is_word   (is_word),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // RISC-V division semantics computed with plain integer arithmetic.
    function automatic void ref_div(input logic sgn, input logic wrd,
                                    input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] q, output logic [63:0] r,
                                    output int lat);
        logic [31:0] a32, b32, q32, r32;
        int          sa32, sb32;
        longint      sa64, sb64;
        a32 = a[31:0];
        b32 = b[31:0];
        if (wrd) begin
            lat = 33;
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32; lat = 1;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'd0; lat = 1;
            end else if (sgn) begin
                sa32 = a32; sb32 = b32;
                q32 = 32'(sa32 / sb32);
                r32 = 32'(sa32 % sb32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            lat = 65;
            if (b == 64'd0) begin
                q = '1; r = a; lat = 1;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = 64'd0; lat = 1;
            end else if (sgn) begin
                sa64 = a; sb64 = b;
                q = 64'(sa64 / sb64);
                r = 64'(sa64 % sb64);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    // Issue one op, check latency/result, hold off the consumer for `stall` cycles.
    task automatic run_op(input string tag, input logic sgn, input logic wrd,
                          input logic [63:0] a, input logic [63:0] b, input int stall);
        logic [63:0] eq, er;
        int          elat;
        int          lat;
        ref_div(sgn, wrd, a, b, eq, er, elat);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        is_signed = sgn;
        is_word   = wrd;
        dividend  = a;
        divisor   = b;
        out_ready = 1'b0;
        @(posedge clk); #1;
        // Scramble inputs to show operands were latched.
        in_valid  = 1'b0;
        is_signed = 1'($urandom);
        is_word   = 1'($urandom);
        dividend  = {$urandom, $urandom};
        divisor   = {$urandom, $urandom};
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(elat));
        chk({tag, "_quot"}, quotient, eq);
        chk({tag, "_rem"}, remainder, er);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
            chk({tag, "_hold_quot"}, quotient, eq);
            chk({tag, "_hold_rem"}, remainder, er);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ready_after"}, 64'(in_ready), 64'd1);
        chk({tag, "_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    // Start a 64-bit op, abort it after 20 CALC cycles by flush or reset.
    task automatic abort_op(input string tag, input logic use_reset);
        int seen;
        in_valid  = 1'b1;
        is_signed = 1'b0;
        is_word   = 1'b0;
        dividend  = 64'hDEAD_BEEF_1234_5678;
        divisor   = 64'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        if (use_reset) rst_n = 1'b0; else flush = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        flush = 1'b0;
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        if (use_reset) begin
            chk({tag, "_quot_clr"}, quotient, 64'd0);
            chk({tag, "_rem_clr"}, remainder, 64'd0);
        end
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk({tag, "_no_valid"}, 64'(seen), 64'd0);
        run_op({tag, "_next"}, 1'b0, 1'b0, 64'd100, 64'd10, 0);
    endtask

    initial begin
        logic        sgn, wrd;
        logic [63:0] a, b;
        int          sel;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        is_signed = 1'b0; is_word = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_quot", quotient, 64'd0);
        chk("rst_rem", remainder, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("div_pos", 1'b1, 1'b0, 64'd100, 64'd7, 0);
        run_op("div_neg", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0);
        run_op("divuw", 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 0);
        run_op("divu_zero", 1'b0, 1'b0, 64'h1234, 64'd0, 0);
        run_op("div_ovf", 1'b1, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
        run_op("divw_ovf", 1'b1, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
        run_op("divw_zero", 1'b1, 1'b1, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 0);
        run_op("backpress", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 10);

        // Flush on the accept edge drops the request.
        in_valid = 1'b1; flush = 1'b1; dividend = 64'd9; divisor = 64'd3;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        chk("flush_drop_ready", 64'(in_ready), 64'd1);
        chk("flush_drop_valid", 64'(out_valid), 64'd0);

        abort_op("flush", 1'b0);
        abort_op("reset", 1'b1);

        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom);
            wrd = 1'($urandom);
            sel = int'($urandom_range(0, 9));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case (sel)
                0: b = '0;
                1: begin
                    a = wrd ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = wrd ? {$urandom, 32'hFFFF_FFFF} : '1;
                end
                2: b = {{32{b[63]}}, 28'd0, 4'($urandom_range(1, 15))};
                3: a = 64'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op("rand", sgn, wrd, a, b, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
